// File: rtl/jac18_pkg.sv
// Shared Jac1-8 CPU definitions: opcodes, field positions, status bit indices
// and the decoder control bundle.
package jac18_pkg;

  localparam int DataWidth         = 8;
  localparam int SEL_WIDTH         = 2;
  localparam int PROGRAM_DataWidth = 16;
  localparam int NumOpCodeBits     = 5;
  localparam int ParamBits         = 8;
  localparam int NumStatusBits     = 3;

  // MSB position of each register-select field within the program word
  localparam int OP1_BIT_POS = 9;
  localparam int OP2_BIT_POS = 4;

  localparam int STATUS_Z  = 0;
  localparam int STATUS_ST = 1;
  localparam int STATUS_GT = 2;

  localparam logic SEL_ALU     = 1'b1;
  localparam logic SEL_DECODER = 1'b0;

  typedef enum logic [NumOpCodeBits-1:0] {
    Op_NOP  = 5'h00,
    Op_ADD  = 5'h01,
    Op_SUB  = 5'h02,
    Op_AND  = 5'h03,
    Op_OR   = 5'h04,
    Op_NOT  = 5'h05,
    Op_XOR  = 5'h06,
    Op_SHL  = 5'h07,
    Op_SHR  = 5'h08,
    Op_VAL  = 5'h09,
    Op_GOTO = 5'h10,
    Op_IFZ  = 5'h11,
    Op_IFNZ = 5'h12,
    Op_IFEQ = 5'h13,
    Op_IFST = 5'h14,
    Op_IFGT = 5'h15
  } opcode_e;

  typedef struct packed {
    logic rd_en1;
    logic rd_en2;
    logic wr_en;
    logic sel_alu;
    logic cnt_wr_en;
  } ctrl_t;

endpackage

// File: rtl/decoder_branch_cond.sv
// Branch condition evaluator: low three opcode bits of a jump-class opcode
// plus ALU flags -> take. Purely combinational.
module decoder_branch_cond
  import jac18_pkg::*;
(
  input  logic [2:0]               cond_i,
  input  logic [NumStatusBits-1:0] status_i,
  output logic                     take_o
);

  logic z_flag;
  logic st_flag;
  logic gt_flag;

  assign z_flag  = status_i[STATUS_Z];
  assign st_flag = status_i[STATUS_ST];
  assign gt_flag = status_i[STATUS_GT];

  // Encodings follow Op_GOTO..Op_IFGT = 5'h10..5'h15
  always_comb begin
    take_o = 1'b0;
    case (cond_i)
      3'd0:    take_o = 1'b1;
      3'd1:    take_o = z_flag;
      3'd2:    take_o = ~z_flag;
      3'd3:    take_o = ~st_flag & ~gt_flag;
      3'd4:    take_o = st_flag;
      3'd5:    take_o = gt_flag;
      default: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/decoder.sv
// Jac1-8 instruction decoder: field split plus zero-latency control decode,
// with a one-cycle squash of the instruction following a taken jump.
module decoder
  import jac18_pkg::*;
#(
  parameter int DATA_W   = DataWidth,
  parameter int SEL_W    = SEL_WIDTH,
  parameter int PROG_W   = PROGRAM_DataWidth,
  parameter int OPC_W    = NumOpCodeBits,
  parameter int PARAM_W  = ParamBits,
  parameter int STATUS_W = NumStatusBits
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PROG_W-1:0]   instruction,
  input  logic [STATUS_W-1:0] status,
  output logic [OPC_W-1:0]    opcode,
  output logic [DATA_W-1:0]   param,
  output logic [DATA_W-1:0]   literal_adr,
  output logic [SEL_W-1:0]    rd_sel1,
  output logic [SEL_W-1:0]    rd_sel2,
  output logic                rd_en1,
  output logic                rd_en2,
  output logic                wr_en,
  output logic [SEL_W-1:0]    wr_sel,
  output logic                sel_reg_in_alu_decoder,
  output logic                cnt_wr_en
);

  logic [OPC_W-1:0] opc;
  ctrl_t            ctrl_raw;
  ctrl_t            ctrl;
  logic             take;
  logic             squash_q;
  logic             squash_d;
  logic             unused_instr_bit;

  assign opc              = instruction[PROG_W-1 -: OPC_W];
  assign unused_instr_bit = instruction[OP1_BIT_POS+1];

  // Field outputs are raw wiring; neither reset nor squash touches them
  assign opcode      = opc;
  assign param       = DATA_W'(instruction[PARAM_W-1:0]);
  assign literal_adr = DATA_W'(instruction[PARAM_W-1:0]);
  assign rd_sel1     = instruction[OP1_BIT_POS -: SEL_W];
  assign rd_sel2     = instruction[OP2_BIT_POS -: SEL_W];
  assign wr_sel      = instruction[OP1_BIT_POS -: SEL_W];

  decoder_branch_cond u_branch_cond (
    .cond_i   (opc[2:0]),
    .status_i (status),
    .take_o   (take)
  );

  always_comb begin
    ctrl_raw         = '0;
    ctrl_raw.sel_alu = SEL_DECODER;
    case (opc)
      Op_ADD, Op_SUB, Op_AND, Op_OR, Op_XOR: begin
        ctrl_raw.rd_en1  = 1'b1;
        ctrl_raw.rd_en2  = 1'b1;
        ctrl_raw.wr_en   = 1'b1;
        ctrl_raw.sel_alu = SEL_ALU;
      end
      Op_NOT, Op_SHL, Op_SHR: begin
        ctrl_raw.rd_en1  = 1'b1;
        ctrl_raw.wr_en   = 1'b1;
        ctrl_raw.sel_alu = SEL_ALU;
      end
      Op_VAL: begin
        ctrl_raw.wr_en   = 1'b1;
        ctrl_raw.sel_alu = SEL_DECODER;
      end
      // status only reaches the outputs through this arm
      Op_GOTO, Op_IFZ, Op_IFNZ, Op_IFEQ, Op_IFST, Op_IFGT: begin
        ctrl_raw.cnt_wr_en = take;
      end
      default: ctrl_raw = '0;
    endcase
  end

  always_comb begin
    ctrl = ctrl_raw;
    if (squash_q) begin
      ctrl.rd_en1    = 1'b0;
      ctrl.rd_en2    = 1'b0;
      ctrl.wr_en     = 1'b0;
      ctrl.cnt_wr_en = 1'b0;
    end
    if (rst) begin
      ctrl = '0;
    end
  end

  // Uses the gated jump so a squashed jump cannot re-arm the squash
  assign squash_d = ctrl.cnt_wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      squash_q <= 1'b0;
    end else begin
      squash_q <= squash_d;
    end
  end

  assign rd_en1                 = ctrl.rd_en1;
  assign rd_en2                 = ctrl.rd_en2;
  assign wr_en                  = ctrl.wr_en;
  assign sel_reg_in_alu_decoder = ctrl.sel_alu;
  assign cnt_wr_en              = ctrl.cnt_wr_en;

endmodule

// File: tb/tb_decoder.sv
// Randomized and directed bench for decoder with a queue-based scoreboard.
module tb_decoder;

  typedef struct packed {
    logic [4:0] opcode;
    logic [7:0] param;
    logic [7:0] literal_adr;
    logic [1:0] rd_sel1;
    logic [1:0] rd_sel2;
    logic       rd_en1;
    logic       rd_en2;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic       sel;
    logic       cnt_wr_en;
  } obs_t;

  typedef struct {
    obs_t  exp;
    string name;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instruction = 16'h0000;
  logic [2:0]  status = 3'b000;
  logic [4:0]  opcode;
  logic [7:0]  param;
  logic [7:0]  literal_adr;
  logic [1:0]  rd_sel1;
  logic [1:0]  rd_sel2;
  logic        rd_en1;
  logic        rd_en2;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic        sel_reg_in_alu_decoder;
  logic        cnt_wr_en;

  int total = 0;
  int bad = 0;
  sb_entry_t sbq[$];
  bit model_squash = 1'b0;

  always #5 clk = ~clk;

  decoder dut (
    .clk                    (clk),
    .rst                    (rst),
    .instruction            (instruction),
    .status                 (status),
    .opcode                 (opcode),
    .param                  (param),
    .literal_adr            (literal_adr),
    .rd_sel1                (rd_sel1),
    .rd_sel2                (rd_sel2),
    .rd_en1                 (rd_en1),
    .rd_en2                 (rd_en2),
    .wr_en                  (wr_en),
    .wr_sel                 (wr_sel),
    .sel_reg_in_alu_decoder (sel_reg_in_alu_decoder),
    .cnt_wr_en              (cnt_wr_en)
  );

  // Reference: opcode classes and jump rules straight from the instruction table
  function automatic obs_t model(input logic [15:0] ins, input logic [2:0] st,
                                 input bit r, input bit sq);
    obs_t o;
    int   op;
    bit   z, s, g, jump;
    op = int'(ins) / 2048;
    z  = st[0];
    s  = st[1];
    g  = st[2];
    o  = '0;
    o.opcode      = 5'(op);
    o.param       = 8'(int'(ins) % 256);
    o.literal_adr = 8'(int'(ins) % 256);
    o.rd_sel1     = 2'((int'(ins) / 256) % 4);
    o.rd_sel2     = 2'((int'(ins) / 8) % 4);
    o.wr_sel      = 2'((int'(ins) / 256) % 4);
    jump = 1'b0;
    if (op == 1 || op == 2 || op == 3 || op == 4 || op == 6) begin
      o.rd_en1 = 1; o.rd_en2 = 1; o.wr_en = 1; o.sel = 1;
    end else if (op == 5 || op == 7 || op == 8) begin
      o.rd_en1 = 1; o.wr_en = 1; o.sel = 1;
    end else if (op == 9) begin
      o.wr_en = 1;
    end else if (op == 16) jump = 1;
    else if (op == 17) jump = z;
    else if (op == 18) jump = !z;
    else if (op == 19) jump = !s && !g;
    else if (op == 20) jump = s;
    else if (op == 21) jump = g;
    o.cnt_wr_en = jump;
    if (sq) begin
      o.rd_en1 = 0; o.rd_en2 = 0; o.wr_en = 0; o.cnt_wr_en = 0;
    end
    if (r) begin
      o.rd_en1 = 0; o.rd_en2 = 0; o.wr_en = 0; o.cnt_wr_en = 0; o.sel = 0;
    end
    return o;
  endfunction

  task automatic step(input bit r, input logic [15:0] ins, input logic [2:0] st,
                      input string name);
    sb_entry_t e;
    @(posedge clk);
    #1;
    rst         = r;
    instruction = ins;
    status      = st;
    e.exp  = model(ins, st, r, model_squash);
    e.name = name;
    sbq.push_back(e);
    model_squash = !r && e.exp.cnt_wr_en;
  endtask

  function automatic logic [15:0] mk(input int op, input int a, input int b, input int lit);
    return 16'(op * 2048 + a * 256 + b * 8 + lit);
  endfunction

  // Monitor: compares whatever the DUT presents against the oldest expectation
  initial begin
    obs_t act;
    sb_entry_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        act = '{opcode, param, literal_adr, rd_sel1, rd_sel2, rd_en1, rd_en2,
                wr_en, wr_sel, sel_reg_in_alu_decoder, cnt_wr_en};
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ins;
    // Reset holds all controls low, even for a jump and an ALU op
    step(1, mk(5'h10, 0, 0, 8'h12), 3'b000, "rst_goto");
    step(1, 16'h0910, 3'b111, "rst_add");
    step(1, mk(9, 3, 0, 8'h5A), 3'b000, "rst_val");
    step(0, 16'h0000, 3'b000, "nop_after_rst");
    step(0, 16'h0910, 3'b000, "add");
    step(0, 16'h2A00, 3'b000, "not");
    step(0, 16'h4BA5, 3'b000, "val");
    step(0, 16'h803F, 3'b000, "goto");
    step(0, 16'h0910, 3'b000, "add_squashed");
    step(0, 16'h0910, 3'b000, "add_restored");
    // Back-to-back jumps: second one is squashed and must not squash the ADD
    step(0, mk(5'h10, 0, 0, 8'h01), 3'b000, "goto_a");
    step(0, mk(5'h10, 0, 0, 8'h02), 3'b000, "goto_b_squashed");
    step(0, 16'h0910, 3'b000, "add_after_sq_jump");
    for (int c = 0; c < 5; c++) begin
      for (int s = 0; s < 8; s++) begin
        step(0, mk(5'h11 + c, s % 4, s % 3, 8'(s * 17)), 3'(s), "if_cond");
        step(0, 16'h0000, 3'(s), "nop_after_if");
      end
    end
    for (int op = 5'h0A; op <= 5'h1F; op++) begin
      if (op < 5'h10 || op > 5'h15) begin
        step(0, mk(op, op % 4, (op + 1) % 4, 8'(op * 7)), 3'(op), "reserved");
      end
    end
    // Reset asserted right after a taken jump clears the pending squash
    step(0, 16'h803F, 3'b000, "goto_pre_rst");
    step(1, 16'h0910, 3'b000, "rst_mid");
    step(0, 16'h0910, 3'b000, "add_post_rst");
    for (int i = 0; i < 3000; i++) begin
      int op;
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 21));
      ins = {5'(op), 11'($urandom)};
      step($urandom_range(0, 31) == 0, ins, 3'($urandom), "random");
    end
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
